mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares a 4:1, WIDTH-bit mux datapath between four requesters (a,b,c,d).
//  Each cycle it picks one requesting source and drives the mux select.
//  The selected word is registered into a single-entry output stage with a valid/ready handshake.
//  Sits between four producers and one consumer of the shared mux output.
// PARAMETERS
//  WIDTH     4  data width of a, b, c, d and y
//  HOLD_MAX  4  max consecutive beats one owner may keep the grant (used only with ARB_HOLD_EN); >=1
// PORTS
//  clk      in   1      single clock; all state updates on the rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  req      in   4      req[i]=1: source i has a word; a,b,c,d map to i=0,1,2,3
//  a,b,c,d  in   WIDTH  source data; held stable while the matching req is high and not yet granted
//  gnt      out  4      one-hot, combinational; gnt[i]=1 means source i's word is accepted this cycle
//  s        out  2      registered mux select; index of the source whose word is in y
//  y        out  WIDTH  registered output word
//  y_valid  out  1      y holds a valid word
//  y_ready  in   1      consumer accepts y this cycle when y_valid && y_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): y=0, y_valid=0, s=0, gnt=0, last=3, hold_cnt=0.
//   First search after reset therefore starts at source 0.
//  out_free = !y_valid || y_ready.
//  STALL (y_valid && !y_ready): gnt=0; y, s, y_valid, last and hold_cnt all hold.
//  ACCEPT (out_free && |req):
//   - winner w = first i with req[i]=1, searching last+1, last+2, ... mod 4 (wraps 3->0).
//   - gnt[w]=1 in this cycle.
//   - next edge: y=data[w], s=w, y_valid=1, last=w.
//  DRAIN (out_free && req==0): gnt=0; next edge y_valid=0; y and s hold.
//  Latency: req seen on edge N -> y_valid=1 with the word after edge N+1 (1 cycle).
//   Throughput is 1 word/cycle while y_ready=1.
//  Requester contract: on gnt[i] the source drops or advances its word.
//   req[i] still high on the next cycle counts as a new word.
//  Simultaneous consume + accept: y is replaced in the same edge. No bubble, no lost word.
//  Reset mid-operation: all state clears at once. Any word in y is discarded, and gnt goes to 0 at once.
//  States: EMPTY (y_valid=0) and FULL (y_valid=1).
//   EMPTY->FULL on ACCEPT.
//   FULL->FULL on ACCEPT or STALL.
//   FULL->EMPTY on DRAIN.
// CONFIGURATION
//  Macro ARB_HOLD_EN:
//   Defined: if req[last]=1 and hold_cnt < HOLD_MAX-1, then w=last and hold_cnt increments.
//    Otherwise the normal round-robin search runs, skipping last if other requests exist,
//    and hold_cnt resets to 0.
//    hold_cnt is 0..HOLD_MAX-1 ($clog2 width, min 1) and holds during STALL.
//    If req[last] is 0 in an ACCEPT cycle, hold_cnt resets to 0.
//   Undefined: no hold_cnt register. Pure round-robin, so the grant rotates after every beat.
// TESTING
//  1 reset; req=0001, a=5, y_ready=1 -> gnt=0001 that cycle; next edge y=5, s=0, y_valid=1
//  2 req=1111, a..d=1,2,3,4, y_ready=1, no ARB_HOLD_EN -> gnt 0001,0010,0100,1000,0001; y 1,2,3,4,1
//  3 y_valid=1, y_ready=0 for 3 cycles, req=0110 -> gnt=0000, y and s stable; y_ready=1 -> next gnt issued same cycle
//  4 ARB_HOLD_EN, HOLD_MAX=3, req=1111 -> gnt 0001 x3, then 0010 x3, then 0100 x3; s follows one cycle later
//  5 last=1 (s=1), req=1001 -> gnt=1000 (source 3) before 0001; then req=0001 -> gnt=0001 (wrap)
//  6 rst_n=0 asynchronously while y_valid=1, y=7 -> y_valid=0, y=0, gnt=0 before next edge;
//    release with req=0100 -> gnt=0100

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 WIDTH-bit mux into a one-entry valid/ready output stage.
// Optional macro ARB_HOLD_EN lets the current owner keep the grant for up to HOLD_MAX consecutive beats.
module mux4_rr_arbiter #(
   parameter int WIDTH    = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [3:0]       gnt,
   output logic [1:0]       s,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam bit CFG_OK = (HOLD_MAX >= 1);

   state_t           r_state;
   logic [1:0]       r_last;
   logic [1:0]       r_s;
   logic [WIDTH-1:0] r_y;

   logic             w_out_free;
   logic             w_accept;
   logic [1:0]       w_rr;
   logic [1:0]       w_win;
   logic [WIDTH-1:0] w_data;

   assign w_out_free = (r_state == EMPTY) || y_ready;
   assign w_accept   = CFG_OK && w_out_free && (|req);

   // Search starts one past the previous winner; k=4 wraps back onto last itself.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      w_rr  = r_last;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = r_last + 2'(k);
         if (!found && req[idx]) begin
            w_rr  = idx;
            found = 1'b1;
         end
      end
   end

`ifdef ARB_HOLD_EN
   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   logic [HW-1:0] r_hold_cnt;
   logic          r_owned;
   logic          w_hold;

   // No owner exists until the first grant after reset, so that one always comes from the search.
   assign w_hold = r_owned && req[r_last] && (r_hold_cnt < HW'(HOLD_MAX - 1));
   assign w_win  = w_hold ? r_last : w_rr;
`else
   assign w_win  = w_rr;
`endif

   always_comb begin
      unique case (w_win)
         2'd0:    w_data = a;
         2'd1:    w_data = b;
         2'd2:    w_data = c;
         default: w_data = d;
      endcase
   end

   always_comb begin
      gnt = '0;
      if (rst_n && w_accept) begin
         gnt[w_win] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_y        <= '0;
         r_s        <= '0;
         r_last     <= 2'd3;
`ifdef ARB_HOLD_EN
         r_hold_cnt <= '0;
         r_owned    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state    <= FULL;
         r_y        <= w_data;
         r_s        <= w_win;
         r_last     <= w_win;
`ifdef ARB_HOLD_EN
         r_hold_cnt <= w_hold ? r_hold_cnt + 1'b1 : '0;
         r_owned    <= 1'b1;
`endif
      end else if (w_out_free) begin
         r_state    <= EMPTY;
      end
   end

   assign y       = r_y;
   assign s       = r_s;
   assign y_valid = (r_state == FULL);

endmodule
